// File: rtl/imem_arbiter.sv
// imem_arbiter: shares the instruction-memory read port between the fetch
// path (F, fixed priority) and the debug readback path (D). D is guaranteed
// forward progress by a wait counter that boosts it above F after MAX_WAIT
// stalled cycles. Read data is registered and returned one cycle after the
// accept; misaligned or out-of-range addresses return err with zero data.
module imem_arbiter #(
  parameter int unsigned MEM_DEPTH_WORDS = 1024,
  parameter int unsigned MAX_WAIT        = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arb_en,
  input  logic        f_valid,
  input  logic [31:0] f_addr,
  output logic        f_ready,
  output logic        f_rsp_valid,
  output logic [31:0] f_rsp_data,
  output logic        f_rsp_err,
  input  logic        d_valid,
  input  logic [31:0] d_addr,
  output logic        d_ready,
  output logic        d_rsp_valid,
  output logic [31:0] d_rsp_data,
  output logic        d_rsp_err,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_instr
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 8;

  logic          w_boost;
  logic          w_f_acc;
  logic          w_d_acc;
  logic          w_f_err;
  logic          w_d_err;
  logic [CW-1:0] w_wait_nxt;

  logic [CW-1:0] r_wait_cnt;
  logic          r_f_rsp_valid;
  logic [DW-1:0] r_f_rsp_data;
  logic          r_f_rsp_err;
  logic          r_d_rsp_valid;
  logic [DW-1:0] r_d_rsp_data;
  logic          r_d_rsp_err;

  // Misaligned or beyond the last word of imem.
  function automatic logic addr_err(input logic [AW-1:0] a);
    return (a[1:0] != 2'b00) || ({2'b00, a[AW-1:2]} >= AW'(MEM_DEPTH_WORDS));
  endfunction

  // Grant logic: F wins unless D has waited MAX_WAIT cycles (BOOST).
  always_comb begin
    w_boost  = d_valid && (r_wait_cnt == CW'(MAX_WAIT));
    f_ready  = arb_en && !w_boost;
    d_ready  = arb_en && (w_boost || !f_valid);
    w_f_acc  = f_valid && f_ready;
    w_d_acc  = d_valid && d_ready;
    mem_addr = w_d_acc ? d_addr : f_addr;
    w_f_err  = addr_err(f_addr);
    w_d_err  = addr_err(d_addr);
  end

  // Wait counter next value: clears on D accept/idle, counts stalls, holds while disabled.
  always_comb begin
    w_wait_nxt = r_wait_cnt;
    if (!d_valid || w_d_acc) begin
      w_wait_nxt = '0;
    end else if (arb_en && !d_ready && (r_wait_cnt < CW'(MAX_WAIT))) begin
      w_wait_nxt = r_wait_cnt + CW'(1);
    end
  end

  // Wait counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_cnt <= '0;
    end else begin
      r_wait_cnt <= w_wait_nxt;
    end
  end

  // Fetch response: one-cycle valid pulse, data/err held until the next response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_f_rsp_valid <= 1'b0;
      r_f_rsp_data  <= '0;
      r_f_rsp_err   <= 1'b0;
    end else begin
      r_f_rsp_valid <= w_f_acc;
      if (w_f_acc) begin
        r_f_rsp_data <= w_f_err ? '0 : mem_instr;
        r_f_rsp_err  <= w_f_err;
      end
    end
  end

  // Debug response: same timing and hold behaviour as the fetch port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_d_rsp_valid <= 1'b0;
      r_d_rsp_data  <= '0;
      r_d_rsp_err   <= 1'b0;
    end else begin
      r_d_rsp_valid <= w_d_acc;
      if (w_d_acc) begin
        r_d_rsp_data <= w_d_err ? '0 : mem_instr;
        r_d_rsp_err  <= w_d_err;
      end
    end
  end

  assign f_rsp_valid = r_f_rsp_valid;
  assign f_rsp_data  = r_f_rsp_data;
  assign f_rsp_err   = r_f_rsp_err;
  assign d_rsp_valid = r_d_rsp_valid;
  assign d_rsp_data  = r_d_rsp_data;
  assign d_rsp_err   = r_d_rsp_err;

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Shares the single read port of the instruction memory between two requesters: the CPU fetch path (port F) and the debug/trace readback path (port D).
- Port F has fixed priority. A wait counter guarantees port D forward progress.
- Grants at most one access per cycle. Registers the memory read data and returns it with a fixed 1-cycle latency.
- Flags misaligned and out-of-range addresses. Sits between the fetch stage and imem.

Parameters:
- MEM_DEPTH_WORDS, 1024, number of 32-bit words in imem; word indices at or above this are out of range.
- MAX_WAIT, 4, stalled cycles after which port D is boosted above port F (range 1..255).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- arb_en  input  1  arbiter enable; when 0 neither port is ready
- f_valid  input  1  fetch request valid
- f_addr  input  32  fetch byte address
- f_ready  output  1  fetch request accepted this cycle (when f_valid)
- f_rsp_valid  output  1  fetch response valid (1-cycle pulse)
- f_rsp_data  output  32  fetch instruction word
- f_rsp_err  output  1  fetch request was misaligned or out of range
- d_valid  input  1  debug request valid
- d_addr  input  32  debug byte address
- d_ready  output  1  debug request accepted this cycle (when d_valid)
- d_rsp_valid  output  1  debug response valid (1-cycle pulse)
- d_rsp_data  output  32  debug instruction word
- d_rsp_err  output  1  debug request was misaligned or out of range
- mem_addr  output  32  byte address to imem (combinational)
- mem_instr  input  32  imem read data (combinational from mem_addr)

Behaviour:
- Reset (async, rst=1):
  - All rsp_valid, rsp_err and rsp_data = 0.
  - Wait counter = 0. Pending responses are discarded and not replayed.
- Boost signal: boost = d_valid && (wait_cnt == MAX_WAIT).
- Ready logic (combinational, may depend on valid):
  - f_ready = arb_en && !boost.
  - d_ready = arb_en && (boost || !f_valid).
- Accept rule: a port is accepted when valid && ready. Both ports are never accepted in the same cycle.
- mem_addr:
  - = d_addr when d is accepted; otherwise = f_addr.
  - The idle value has no functional meaning.
- Response timing: on the rising edge that ends an accept cycle, the accepted port's rsp_valid <= 1 for exactly one cycle.
- Response contents:
  - rsp_data <= mem_instr, or 0 when err.
  - rsp_err <= (addr[1:0] != 0) || (addr[31:2] >= MEM_DEPTH_WORDS).
  - Misaligned takes precedence only in that both conditions set the same single err bit.
- Responses have no backpressure.
- Data hold: rsp_data and rsp_err hold their last value until the next response on that port. rsp_valid is 0 in non-accept cycles.
- Back-to-back accepts on the same port give a response every cycle. Throughput is 1 per cycle total.
- Wait counter (8-bit):
  - Increments, saturating at MAX_WAIT, each cycle d_valid && !d_ready.
  - Cleared to 0 when d is accepted or d_valid == 0.
  - Holds its value while arb_en == 0 and d_valid == 1; it does not count while disabled.
- Boost after a grant: after a boosted D grant the counter is 0, so F regains priority the next cycle. Worst-case D latency is MAX_WAIT+1 cycles under continuous F traffic.
- Requester contract: requesters must hold valid and addr stable until accepted. The arbiter does not check this.
- Address width: only addr[31:2] indexes memory. addr[1:0] are used only for the err check.
- State machine: implicit two-state on boost (NORMAL: F priority; BOOST: D priority), driven by the counter.

Test Plan:
- Reset then f_valid=1, f_addr=0x00000004, d_valid=0 -> f_ready=1; next cycle f_rsp_valid=1, f_rsp_data=0x00100093, f_rsp_err=0.
- f_valid=1 on 0x0, 0x4, 0x8 in consecutive cycles -> f_rsp_data 0x00000013, 0x00100093, 0x00200113 on consecutive cycles; d_valid=0 throughout.
- Contention:
  - Stimulus: f_valid=1 continuously; d_valid=1, d_addr=0x0000003C.
  - Expected: d_ready=0 for 4 cycles, then d_ready=1 and f_ready=0 for exactly one cycle.
  - Next cycle: d_rsp_valid=1, d_rsp_data=0x00f68793; F resumes the cycle after the boost.
- Error addresses (each -> next cycle rsp_valid=1, rsp_err=1, rsp_data=0):
  - f_addr=0x00000005 (misaligned).
  - d_addr=0x00001000 (word 1024, out of range).
- arb_en=0 with both valid for 10 cycles -> both ready=0, no responses, wait_cnt stays 0. arb_en=1 -> F accepted first.
- Assert rst for one cycle in the cycle after an accepted F request -> f_rsp_valid=0 immediately and stays 0, f_rsp_data=0, wait_cnt=0.
